spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI slave endpoint that answers spi_bus masters elsewhere in the design.
- Oversamples SCLK/CS/SI in its own clk domain and deserialises MSB-first words from the master into d_in.
- Simultaneously shifts a preloaded response word out on SO.
- Protocol: CS active-low framing; master drives data on SCLK falling edge; both sides sample on SCLK rising edge; SCLK idles low.

Parameters:
- BUS_WIDTH, 8, word width in bits.
- CNT_SIZE, 3, bit-counter width; 2**CNT_SIZE >= BUS_WIDTH.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2).

Ports:
- clk  input  1  system clock; must be >= 4x the SCLK frequency.
- rst  input  1  synchronous, active-high reset.
- SCLK  input  1  serial clock from master.
- CS  input  1  chip select from master, active low.
- SI  input  1  serial data from master (master SO).
- SO  output  1  serial data to master (master SI).
- so_oe  output  1  SO drive enable; high while the frame is active.
- d_out  input  BUS_WIDTH  response word to transmit.
- tx_load  input  1  single-cycle strobe; captures d_out into the holding register.
- tx_ready  output  1  holding register empty; may accept a new word.
- d_in  output  BUS_WIDTH  last complete received word.
- rx_valid  output  1  one-cycle pulse when d_in updates.
- frame_err  output  1  one-cycle pulse when CS rises mid-word.
- busy  output  1  frame in progress (synchronised CS low).

Behaviour:
- Reset (clk edge with rst=1):
  - Outputs: SO=1, so_oe=0, tx_ready=1, d_in=0, rx_valid=0, frame_err=0, busy=0.
  - Internal: holding register = all-ones, shift registers = 0, bit counter = 0, state = IDLE.
  - Reset mid-frame aborts immediately, with no rx_valid or frame_err pulse.
- Input conditioning:
  - SCLK and CS each pass through SYNC_STAGES flops plus one edge-detect flop, giving rise/fall strobes.
  - SI is synchronised with the same depth so it stays aligned with SCLK.
- Holding register:
  - tx_load captures d_out and clears tx_ready.
  - A tx_load while tx_ready=0 overwrites the holding register.
  - When the holding register transfers to the tx shifter, tx_ready sets.
  - If tx_load and the transfer fall in the same cycle, the shifter takes the old holding value, the new d_out is stored, and tx_ready stays 0.
  - If no word was loaded, the shifter takes all-ones (underrun fill).
- State machine: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on CS fall strobe. In that cycle: load tx shifter from holding register, clear bit counter and rx shifter, set busy=1, so_oe=1, SO = tx shifter MSB.
  - SHIFT, on SCLK rise strobe: rx shifter <= {rx[BUS_WIDTH-2:0], SI_sync}; counter increments. When the counter reaches BUS_WIDTH-1 before incrementing, go to DONE.
  - SHIFT, on SCLK fall strobe: tx shifter shifts left by one; SO = new MSB.
  - DONE (exactly 1 cycle): d_in <= rx shifter, rx_valid=1. Reload tx shifter from holding register, counter=0, SO = new MSB. Then go to SHIFT if CS is still low, else IDLE. This allows back-to-back words within one CS frame.
  - Any state, on CS rise strobe: go to IDLE; busy=0, so_oe=0, SO=1.
    - If the counter is nonzero in SHIFT: frame_err pulses 1 cycle, the partial word is discarded, d_in is unchanged.
    - If CS rise coincides with DONE: the word completes (rx_valid=1) and frame_err stays 0.
- Edge priority within one cycle: CS rise > SCLK rise > SCLK fall. SCLK edges while in IDLE are ignored.
- Latency: rx_valid asserts SYNC_STAGES+2 clk cycles (±1 for sampling phase) after the raw SCLK rising edge of the final bit.
- Arithmetic: bit counter is CNT_SIZE+1 bits and is never compared beyond BUS_WIDTH-1. No wrap-around is possible because DONE resets it.

Decomposition:
- Package spi_pkg holds:
  - state encodings (SPI_IDLE, SPI_SHIFT, SPI_DONE);
  - the underrun fill constant (all-ones);
  - the shared default BUS_WIDTH/CNT_SIZE.
- Sub-module spi_sync_edge (parameter SYNC_STAGES):
  - outputs: synchronised level, rise strobe, fall strobe;
  - instantiated for SCLK and CS;
  - SI uses its level output only.

Test Plan:
- Load 0xA5, then master sends 0x3C in one CS frame at clk/8 SCLK -> d_in=0x3C with a single rx_valid pulse; master receives 0xA5; tx_ready=1 after the frame; frame_err=0.
- No tx_load, master sends 0x81 -> d_in=0x81; SO shifts 0xFF (underrun fill).
- One CS frame with two words 0x12, 0x34, second d_out=0x56 loaded during word 1 -> two rx_valid pulses (0x12, then 0x34); master receives 0xA5, then 0x56.
- CS deasserted after 5 bits of 0xF0 -> frame_err pulses once; rx_valid stays 0; d_in keeps its previous value; so_oe=0 and SO=1 within SYNC_STAGES+2 cycles.
- Assert rst after bit 3 of an active frame -> all outputs at reset values the next cycle. A following full frame 0x5A is received correctly.
- tx_load in the same cycle as the CS-fall strobe (holding=0x11, d_out=0x22) -> frame transmits 0x11; tx_ready=0; next frame transmits 0x22.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave endpoint.
package spi_pkg;

  localparam int unsigned SPI_BUS_WIDTH = 8;
  localparam int unsigned SPI_CNT_SIZE  = 3;
  localparam int unsigned SPI_MAX_WIDTH = 64;

  // Word shifted out when the master clocks a word that software never loaded.
  localparam logic [SPI_MAX_WIDTH-1:0] SPI_UNDERRUN_FILL = '1;

  typedef enum logic [1:0] {
    SPI_IDLE  = 2'd0,
    SPI_SHIFT = 2'd1,
    SPI_DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the parallel load/receive handshake of the slave endpoint.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = SPI_BUS_WIDTH
) ();

  logic                 SCLK;
  logic                 CS;
  logic                 SI;
  logic                 SO;
  logic                 so_oe;
  logic [BUS_WIDTH-1:0] d_out;
  logic                 tx_load;
  logic                 tx_ready;
  logic [BUS_WIDTH-1:0] d_in;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  SCLK, CS, SI, d_out, tx_load,
    output SO, so_oe, tx_ready, d_in, rx_valid, frame_err, busy
  );

  modport master (
    output SCLK, CS, SI, d_out, tx_load,
    input  SO, so_oe, tx_ready, d_in, rx_valid, frame_err, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one extra flop for rise/fall strobe detection.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = level & ~prev_q;
  assign fall_c = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave (CS active low, sample on SCLK rise, MSB first) oversampled in the clk domain.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = SPI_BUS_WIDTH,
  parameter int unsigned CNT_SIZE    = SPI_CNT_SIZE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  localparam int unsigned          CW       = CNT_SIZE + 1;
  localparam logic [CW-1:0]        LAST_BIT = CW'(BUS_WIDTH - 1);
  localparam logic [BUS_WIDTH-1:0] FILL     = SPI_UNDERRUN_FILL[BUS_WIDTH-1:0];

  logic sclk_level_unused, sclk_rise_c, sclk_fall_c;
  logic cs_level_unused, cs_rise_c, cs_fall_c;
  logic si_sync, si_rise_unused, si_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(bus.SCLK),
    .level(sclk_level_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(bus.CS),
    .level(cs_level_unused), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_si_sync (
    .clk(clk), .rst(rst), .din(bus.SI),
    .level(si_sync), .rise_c(si_rise_unused), .fall_c(si_fall_unused)
  );

  spi_state_e           state_q;
  logic [BUS_WIDTH-1:0] hold_q, tx_shift_q, rx_shift_q, d_in_q;
  logic [CW-1:0]        cnt_q;
  logic                 tx_ready_q, tx_pend_q;
  logic                 rx_valid_q, frame_err_q, busy_q, so_oe_q, so_q;
  logic [BUS_WIDTH-1:0] next_word;

  assign next_word = tx_ready_q ? FILL : hold_q;

  // tx_pend_q: the shifter holds a copy of the holding register taken at a word
  // boundary; the copy only counts as consumed once that word's first bit is clocked,
  // so a frame that ends on the boundary leaves the loaded word for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SPI_IDLE;
      hold_q      <= FILL;
      tx_ready_q  <= 1'b1;
      tx_pend_q   <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      cnt_q       <= '0;
      d_in_q      <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      so_oe_q     <= 1'b0;
      so_q        <= 1'b1;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (bus.tx_load) begin
        hold_q     <= bus.d_out;
        tx_ready_q <= 1'b0;
        tx_pend_q  <= 1'b0;
      end

      if (cs_rise_c && state_q != SPI_IDLE) begin
        state_q   <= SPI_IDLE;
        busy_q    <= 1'b0;
        so_oe_q   <= 1'b0;
        so_q      <= 1'b1;
        tx_pend_q <= 1'b0;
        if (state_q == SPI_SHIFT) begin
          frame_err_q <= (cnt_q != '0);
        end else begin
          d_in_q     <= rx_shift_q;
          rx_valid_q <= 1'b1;
          cnt_q      <= '0;
        end
      end else begin
        case (state_q)
          SPI_IDLE: begin
            if (cs_fall_c) begin
              tx_shift_q <= next_word;
              so_q       <= next_word[BUS_WIDTH-1];
              if (!bus.tx_load) begin
                hold_q     <= FILL;
                tx_ready_q <= 1'b1;
              end
              cnt_q      <= '0;
              rx_shift_q <= '0;
              busy_q     <= 1'b1;
              so_oe_q    <= 1'b1;
              state_q    <= SPI_SHIFT;
            end
          end
          SPI_SHIFT: begin
            if (sclk_rise_c) begin
              rx_shift_q <= {rx_shift_q[BUS_WIDTH-2:0], si_sync};
              cnt_q      <= cnt_q + CW'(1);
              if (cnt_q == LAST_BIT) state_q <= SPI_DONE;
              if (tx_pend_q && !bus.tx_load) begin
                hold_q     <= FILL;
                tx_ready_q <= 1'b1;
              end
              tx_pend_q <= 1'b0;
            end else if (sclk_fall_c && cnt_q != '0) begin
              // the fall before a word's first rise belongs to the previous word
              tx_shift_q <= {tx_shift_q[BUS_WIDTH-2:0], 1'b0};
              so_q       <= tx_shift_q[BUS_WIDTH-2];
            end
          end
          SPI_DONE: begin
            d_in_q     <= rx_shift_q;
            rx_valid_q <= 1'b1;
            cnt_q      <= '0;
            tx_shift_q <= next_word;
            so_q       <= next_word[BUS_WIDTH-1];
            tx_pend_q  <= !tx_ready_q && !bus.tx_load;
            state_q    <= SPI_SHIFT;
          end
          default: state_q <= SPI_IDLE;
        endcase
      end
    end
  end

  assign bus.SO        = so_q;
  assign bus.so_oe     = so_oe_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.d_in      = d_in_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: table vectors, hand-written corner sequences, random frames vs a word-level model.
module tb_spi_slave;

  localparam int unsigned W    = 8;
  localparam int unsigned HALF = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_if #(.BUS_WIDTH(W)) bus ();

  spi_slave #(.BUS_WIDTH(W), .CNT_SIZE(3), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec;
  int n_err;
  int ferr_cnt;
  logic [W-1:0] rx_q[$];

  always @(negedge clk) begin
    if (bus.rx_valid) rx_q.push_back(bus.d_in);
    if (bus.frame_err) ferr_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    bus.d_out   = v;
    bus.tx_load = 1'b1;
    tick();
    bus.tx_load = 1'b0;
  endtask

  // Master side: drive SI after each fall, sample SO at each rise; optional load at bit 3.
  task automatic send_bits(input logic [W-1:0] mosi, input int nbits, input bit ld,
                           input logic [W-1:0] ld_val, output logic [W-1:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.SI = mosi[3'(7 - i)];
      for (int c = 0; c < int'(HALF); c++) begin
        if (ld && i == 3 && c == 0) begin
          bus.d_out   = ld_val;
          bus.tx_load = 1'b1;
        end
        tick();
        bus.tx_load = 1'b0;
      end
      bus.SCLK = 1'b1;
      miso[3'(7 - i)] = bus.SO;
      repeat (HALF) tick();
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic end_frame();
    repeat (HALF) tick();
    bus.CS = 1'b1;
    repeat (8) tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " SO"},        bus.SO, 1);
    check({tag, " so_oe"},     bus.so_oe, 0);
    check({tag, " tx_ready"},  bus.tx_ready, 1);
    check({tag, " d_in"},      bus.d_in, 0);
    check({tag, " rx_valid"},  bus.rx_valid, 0);
    check({tag, " frame_err"}, bus.frame_err, 0);
    check({tag, " busy"},      bus.busy, 0);
  endtask

  function automatic logic [W-1:0] pop_rx();
    if (rx_q.size() > 0) return rx_q.pop_front();
    return 'x;
  endfunction

  typedef struct {
    bit           ld;
    logic [W-1:0] ld_val;
    logic [W-1:0] mosi;
    logic [W-1:0] exp_din;
    logic [W-1:0] exp_miso;
  } vec_t;

  initial begin
    vec_t         vt[5];
    logic [W-1:0] m1, m2, v, exp_tx, mosi, lv;
    logic [W-1:0] exp_rx[$];
    bit           ld, mdl_valid;
    logic [W-1:0] mdl_val;
    int           ferr0, nw;

    n_vec = 0; n_err = 0; ferr_cnt = 0;
    bus.SCLK = 1'b0; bus.CS = 1'b1; bus.SI = 1'b0;
    bus.tx_load = 1'b0; bus.d_out = '0;
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2) tick();

    vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vt[1] = '{1'b0, 8'h00, 8'h81, 8'h81, 8'hFF};
    vt[2] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vt[3] = '{1'b1, 8'h80, 8'h01, 8'h01, 8'h80};
    vt[4] = '{1'b1, 8'h7E, 8'hC3, 8'hC3, 8'h7E};

    for (int r = 0; r < 5; r++) begin
      ferr0 = ferr_cnt;
      if (vt[r].ld) begin
        do_load(vt[r].ld_val);
        check($sformatf("row%0d tx_ready_after_load", r), bus.tx_ready, 0);
      end
      bus.CS = 1'b0;
      send_bits(vt[r].mosi, 8, 1'b0, '0, m1);
      end_frame();
      check($sformatf("row%0d rx_pulses", r), rx_q.size(), 1);
      check($sformatf("row%0d d_in", r), pop_rx(), vt[r].exp_din);
      check($sformatf("row%0d miso", r), m1, vt[r].exp_miso);
      check($sformatf("row%0d tx_ready", r), bus.tx_ready, 1);
      check($sformatf("row%0d frame_err", r), ferr_cnt, ferr0);
      check($sformatf("row%0d idle_pins", r), {bus.so_oe, bus.SO, bus.busy}, 3'b010);
    end

    // Two words in one frame, second response loaded mid word one.
    ferr0 = ferr_cnt;
    do_load(8'hA5);
    bus.CS = 1'b0;
    send_bits(8'h12, 8, 1'b1, 8'h56, m1);
    send_bits(8'h34, 8, 1'b0, '0, m2);
    end_frame();
    check("b2b rx_pulses", rx_q.size(), 2);
    check("b2b word0", pop_rx(), 8'h12);
    check("b2b word1", pop_rx(), 8'h34);
    check("b2b miso0", m1, 8'hA5);
    check("b2b miso1", m2, 8'h56);
    check("b2b tx_ready", bus.tx_ready, 1);
    check("b2b frame_err", ferr_cnt, ferr0);

    // CS released after 5 bits.
    ferr0 = ferr_cnt;
    bus.CS = 1'b0;
    send_bits(8'hF0, 5, 1'b0, '0, m1);
    bus.CS = 1'b1;
    repeat (4) tick();
    check("abort so_oe", bus.so_oe, 0);
    check("abort SO", bus.SO, 1);
    check("abort busy", bus.busy, 0);
    repeat (8) tick();
    check("abort frame_err_pulses", ferr_cnt, ferr0 + 1);
    check("abort rx_pulses", rx_q.size(), 0);
    check("abort d_in_kept", bus.d_in, 8'h34);

    // Reset in the middle of a frame.
    ferr0 = ferr_cnt;
    bus.CS = 1'b0;
    send_bits(8'hC3, 3, 1'b0, '0, m1);
    bus.CS = 1'b1;
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0;
    repeat (8) tick();
    check("midrst no_frame_err", ferr_cnt, ferr0);
    check("midrst no_rx", rx_q.size(), 0);
    bus.CS = 1'b0;
    send_bits(8'h5A, 8, 1'b0, '0, m1);
    end_frame();
    check("midrst rx_pulses", rx_q.size(), 1);
    check("midrst d_in", pop_rx(), 8'h5A);
    check("midrst miso", m1, 8'hFF);

    // tx_load coincides with the CS-fall strobe (two synchroniser flops after CS).
    do_load(8'h11);
    bus.CS = 1'b0;
    bus.SI = 1'b1;
    tick(); tick();
    bus.d_out = 8'h22;
    bus.tx_load = 1'b1;
    tick();
    bus.tx_load = 1'b0;
    check("coinc tx_ready_at_start", bus.tx_ready, 0);
    send_bits(8'h99, 8, 1'b0, '0, m1);
    end_frame();
    check("coinc miso0", m1, 8'h11);
    check("coinc tx_ready_after", bus.tx_ready, 0);
    check("coinc d_in", pop_rx(), 8'h99);
    bus.CS = 1'b0;
    send_bits(8'h66, 8, 1'b0, '0, m2);
    end_frame();
    check("coinc miso1", m2, 8'h22);
    check("coinc tx_ready_final", bus.tx_ready, 1);
    check("coinc d_in1", pop_rx(), 8'h66);

    // Random frames against a word-level model: each word that starts shifting
    // consumes the held response if one is present, otherwise all-ones is sent.
    mdl_valid = 1'b0;
    mdl_val   = '0;
    for (int f = 0; f < 30; f++) begin
      ferr0 = ferr_cnt;
      exp_rx.delete();
      if ($urandom_range(0, 1) == 1) begin
        v = W'($urandom);
        do_load(v);
        mdl_valid = 1'b1;
        mdl_val   = v;
      end
      nw = int'($urandom_range(1, 3));
      bus.CS = 1'b0;
      for (int k = 0; k < nw; k++) begin
        mosi = W'($urandom);
        ld   = ($urandom_range(0, 1) == 1);
        lv   = W'($urandom);
        exp_tx = mdl_valid ? mdl_val : 8'hFF;
        mdl_valid = 1'b0;
        send_bits(mosi, 8, ld, lv, m1);
        if (ld) begin
          mdl_valid = 1'b1;
          mdl_val   = lv;
        end
        check($sformatf("rand f%0d w%0d miso", f, k), m1, exp_tx);
        exp_rx.push_back(mosi);
      end
      end_frame();
      check($sformatf("rand f%0d rx_pulses", f), rx_q.size(), nw);
      foreach (exp_rx[k]) check($sformatf("rand f%0d w%0d d_in", f, k), pop_rx(), exp_rx[k]);
      check($sformatf("rand f%0d tx_ready", f), bus.tx_ready, !mdl_valid);
      check($sformatf("rand f%0d frame_err", f), ferr_cnt, ferr0);
      rx_q.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
